// File: rtl/axil_arbiter_wr_rr.sv
`default_nettype none
// ============================================================================
// Module   : axil_arbiter_wr_rr
// Purpose  : AXI-Lite write-channel arbiter, fixed-priority or round-robin,
//            with zero-bubble regrant. Optional watchdog: AXIL_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axil_arbiter_wr_rr #(
    parameter int NUMBER_MASTER  = 4,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUMBER_MASTER-1:0]         request_wr,
    output logic [NUMBER_MASTER-1:0]         grant_wr,
    output logic [$clog2(NUMBER_MASTER)-1:0] grant_wr_id,
    output logic                             grant_valid,
    input  logic                             s_axil_bvalid,
    input  logic [NUMBER_MASTER-1:0]         m_axil_bready,
    output logic                             timeout_err
);

    localparam int ID_W  = $clog2(NUMBER_MASTER);
    localparam int IDX_W = ID_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACKN = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [NUMBER_MASTER-1:0] grant_q, grant_d;
    logic [ID_W-1:0]          grant_id_q, grant_id_d;
    logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;

    logic                     w_done;
    logic                     w_timeout_hit;
    logic                     w_release;
    logic                     w_load;
    logic [ID_W-1:0]          w_ptr_next;
    logic [ID_W-1:0]          w_start;
    logic [ID_W-1:0]          w_sel;

    // First set request bit at or after ptr, wrapping modulo NUMBER_MASTER.
    function automatic logic [ID_W-1:0] f_select(
        input logic [NUMBER_MASTER-1:0] req,
        input logic [ID_W-1:0]          ptr
    );
        logic [ID_W-1:0]  sel;
        logic             found;
        logic [IDX_W-1:0] idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUMBER_MASTER; i++) begin
            idx = {1'b0, ptr} + IDX_W'(i);
            if (idx >= IDX_W'(NUMBER_MASTER)) begin
                idx = idx - IDX_W'(NUMBER_MASTER);
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[ID_W-1:0];
            end
        end
        return sel;
    endfunction

    function automatic logic [ID_W-1:0] f_incr(input logic [ID_W-1:0] id);
        logic [IDX_W-1:0] s;
        s = {1'b0, id} + IDX_W'(1);
        if (s == IDX_W'(NUMBER_MASTER)) begin
            s = '0;
        end
        return s[ID_W-1:0];
    endfunction

    assign grant_wr    = grant_q;
    assign grant_wr_id = grant_id_q;
    assign grant_valid = |grant_q;

    assign w_done     = grant_valid && s_axil_bvalid && m_axil_bready[grant_id_q];
    assign w_release  = w_done || w_timeout_hit;
    // The regrant search in the releasing cycle must already see the advanced pointer.
    assign w_ptr_next = w_release ? f_incr(grant_id_q) : rr_ptr_q;
    assign w_start    = (ARB_MODE == 1) ? w_ptr_next : '0;
    assign w_sel      = f_select(request_wr, w_start);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = w_ptr_next;
        w_load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|request_wr) begin
                    w_load = 1'b1;
                end
            end
            ST_ACKN: begin
                if (w_release) begin
                    if (|request_wr) begin
                        w_load = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        grant_id_d = '0;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
            end
        endcase
        if (w_load) begin
            state_d    = ST_ACKN;
            grant_d    = {{(NUMBER_MASTER-1){1'b0}}, 1'b1} << w_sel;
            grant_id_d = w_sel;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // A completion in the expiry cycle takes precedence over the watchdog.
    assign w_timeout_hit = (state_q == ST_ACKN) && !w_done &&
                           (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d     = tmo_cnt_q + CNT_W'(1);
        timeout_err_d = w_timeout_hit;
        if (w_load || w_release || (state_q != ST_ACKN)) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout_hit    = 1'b0;
    assign timeout_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axil_arbiter_wr_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_arbiter_wr_rr
// Purpose  : Self-checking bench: three arbiter configurations against a
//            behavioural model, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_arbiter_wr_rr;

    localparam int TMO = 8;
`ifdef AXIL_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       aresetn = 1'b0;
    logic [4:0] req     = '0;
    logic [4:0] bready  = '0;
    logic       bvalid  = 1'b0;
    bit         cmp_en  = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [3:0] g0, g1;
    logic [4:0] g2;
    logic [1:0] i0, i1;
    logic [2:0] i2;
    logic       v0, v1, v2, t0, t1, t2;

    always #5 clk = ~clk;

    // k=0: round-robin N=4, k=1: fixed priority N=4, k=2: round-robin N=5
    axil_arbiter_wr_rr #(.NUMBER_MASTER(4), .ARB_MODE(1), .TIMEOUT_CYCLES(TMO)) u_rr4 (
        .aclk(clk), .aresetn(aresetn), .request_wr(req[3:0]), .grant_wr(g0),
        .grant_wr_id(i0), .grant_valid(v0), .s_axil_bvalid(bvalid),
        .m_axil_bready(bready[3:0]), .timeout_err(t0));
    axil_arbiter_wr_rr #(.NUMBER_MASTER(4), .ARB_MODE(0), .TIMEOUT_CYCLES(TMO)) u_fp4 (
        .aclk(clk), .aresetn(aresetn), .request_wr(req[3:0]), .grant_wr(g1),
        .grant_wr_id(i1), .grant_valid(v1), .s_axil_bvalid(bvalid),
        .m_axil_bready(bready[3:0]), .timeout_err(t1));
    axil_arbiter_wr_rr #(.NUMBER_MASTER(5), .ARB_MODE(1), .TIMEOUT_CYCLES(TMO)) u_rr5 (
        .aclk(clk), .aresetn(aresetn), .request_wr(req), .grant_wr(g2),
        .grant_wr_id(i2), .grant_valid(v2), .s_axil_bvalid(bvalid),
        .m_axil_bready(bready), .timeout_err(t2));

    logic [4:0] dg [3];
    logic [2:0] di [3];
    logic       dv [3];
    logic       dt [3];
    assign dg[0] = {1'b0, g0};
    assign dg[1] = {1'b0, g1};
    assign dg[2] = g2;
    assign di[0] = {1'b0, i0};
    assign di[1] = {1'b0, i1};
    assign di[2] = i2;
    assign dv[0] = v0;
    assign dv[1] = v1;
    assign dv[2] = v2;
    assign dt[0] = t0;
    assign dt[1] = t1;
    assign dt[2] = t2;

    // Model: owner index (-1 = none), rotation pointer, watchdog age, pulse.
    int nn [3] = '{4, 4, 5};
    int md [3] = '{1, 0, 1};
    int mo [3] = '{-1, -1, -1};
    int mp [3] = '{0, 0, 0};
    int mc [3] = '{0, 0, 0};
    int mt [3] = '{0, 0, 0};

    function automatic int pick(input int r, input int n, input int start);
        for (int i = 0; i < n; i++) begin
            if (r[(start + i) % n]) return (start + i) % n;
        end
        return -1;
    endfunction

    task automatic model_step(input int k);
        int n, r, start;
        bit done, to;
        n = nn[k];
        r = int'(req) & ((1 << n) - 1);
        if (!aresetn) begin
            mo[k] = -1; mp[k] = 0; mc[k] = 0; mt[k] = 0;
            return;
        end
        mt[k] = 0;
        if (mo[k] < 0) begin
            if (r != 0) begin
                start = (md[k] == 1) ? mp[k] : 0;
                mo[k] = pick(r, n, start);
                mc[k] = 0;
            end
        end else begin
            done = bvalid && bready[mo[k]];
            to   = TO_EN && !done && (mc[k] == TMO - 1);
            if (done || to) begin
                mp[k] = (mo[k] + 1) % n;
                mt[k] = to ? 1 : 0;
                if (r != 0) begin
                    start = (md[k] == 1) ? mp[k] : 0;
                    mo[k] = pick(r, n, start);
                    mc[k] = 0;
                end else begin
                    mo[k] = -1;
                end
            end else begin
                mc[k]++;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                check("model_grant", k, 32'(dg[k]), (mo[k] >= 0) ? (32'd1 << mo[k]) : 32'd0);
                check("model_id",    k, 32'(di[k]), (mo[k] >= 0) ? 32'(mo[k]) : 32'd0);
                check("model_valid", k, 32'(dv[k]), (mo[k] >= 0) ? 32'd1 : 32'd0);
                check("model_terr",  k, 32'(dt[k]), 32'(mt[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input logic [4:0] r);
        aresetn = 1'b0;
        req     = r;
        bvalid  = 1'b0;
        bready  = 5'b11111;
        repeat (3) tick();
    endtask

    initial begin
        // reset with every request asserted, then first grant
        hold_reset(5'b11111);
        cmp_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("rst_grant", k, 32'(dg[k]), 32'd0);
            check("rst_id",    k, 32'(di[k]), 32'd0);
            check("rst_valid", k, 32'(dv[k]), 32'd0);
            check("rst_terr",  k, 32'(dt[k]), 32'd0);
        end
        aresetn = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("first_grant", k, 32'(dg[k]), 32'd1);
            check("first_id",    k, 32'(di[k]), 32'd0);
        end

        // fixed priority keeps re-picking the lowest requester
        hold_reset(5'b01010);
        aresetn = 1'b1;
        tick();
        check("fp_id_a", 1, 32'(i1), 32'd1);
        repeat (2) begin
            bvalid = 1'b1; tick(); bvalid = 1'b0;
            check("fp_id_again", 1, 32'(i1), 32'd1);
            check("fp_valid",    1, 32'(v1), 32'd1);
        end
        req = 5'b01000;
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        check("fp_id_drop", 1, 32'(i1), 32'd3);

        // round-robin rotation with no idle gap
        hold_reset(5'b01111);
        aresetn = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("rr_seq_id", 0, 32'(i0), 32'(i % 4));
            check("rr_valid0", 0, 32'(v0), 32'd1);
            tick();
            check("rr_valid1", 0, 32'(v0), 32'd1);
            tick();
            check("rr_valid2", 0, 32'(v0), 32'd1);
            bvalid = 1'b1; tick(); bvalid = 1'b0;
        end

        // N=5 wrap from id 4 with sparse requests
        hold_reset(5'b10000);
        aresetn = 1'b1;
        tick();
        check("wrap_id4", 2, 32'(i2), 32'd4);
        req = 5'b00101;
        bvalid = 1'b1; tick();
        check("wrap_id0", 2, 32'(i2), 32'd0);
        tick(); bvalid = 1'b0;
        check("wrap_id2", 2, 32'(i2), 32'd2);
        check("model_pin_wrap", 2, 32'(mo[2]), 32'd2);

        // B response only counts for the granted master's ready
        hold_reset(5'b00100);
        aresetn = 1'b1;
        tick();
        check("bq_id", 0, 32'(i0), 32'd2);
        bvalid = 1'b1; bready = 5'b00010; tick();
        check("bq_held_id",    0, 32'(i0), 32'd2);
        check("bq_held_valid", 0, 32'(v0), 32'd1);
        req = 5'b00000; bready = 5'b00100; tick(); bvalid = 1'b0;
        check("bq_release", 0, 32'(v0), 32'd0);
        check("bq_grant0",  0, 32'(g0), 32'd0);

`ifdef AXIL_ARB_TIMEOUT_EN
        hold_reset(5'b00011);
        aresetn = 1'b1;
        tick();
        for (int c = 1; c <= TMO; c++) begin
            check("tmo_wait_terr", 0, 32'(t0), 32'd0);
            check("tmo_wait_id",   0, 32'(i0), 32'd0);
            tick();
        end
        check("tmo_pulse",   0, 32'(t0), 32'd1);
        check("tmo_next_id", 0, 32'(i0), 32'd1);
        check("tmo_fp_id",   1, 32'(i1), 32'd0);
        tick();
        check("tmo_pulse_end", 0, 32'(t0), 32'd0);
        repeat (TMO - 2) tick();
        bvalid = 1'b1; tick(); bvalid = 1'b0;
        check("tmo_done_wins", 0, 32'(t0), 32'd0);
        check("tmo_done_id",   0, 32'(i0), 32'd0);
`endif

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            aresetn = ($urandom_range(0, 99) != 0);
            req     = 5'($urandom);
            bvalid  = ($urandom_range(0, 2) == 0);
            bready  = 5'($urandom | $urandom);
            tick();
        end
        aresetn = 1'b1;
        req     = '0;
        bvalid  = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
